// File: rtl/exception_ctrl.sv
// rtl/exception_ctrl.sv - exception sequencer: save EPC, fetch handler vector byte, load PC
// Holds the main control unit stalled while the handler address is read from memory.
module exception_ctrl #(
  parameter logic [7:0] VEC_OPC     = 8'd254,
  parameter logic [7:0] VEC_DIV     = 8'd255,
  parameter logic [7:0] VEC_OVF     = 8'd253,
  parameter int         MEM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        OVERFLOW,
  input  logic        OVF_CHECK,
  input  logic        OPCODE_INVALID,
  input  logic        DIV_ZERO,
  input  logic [31:0] PC,
  input  logic [31:0] MEM_DATA,
  output logic [31:0] MEM_ADDR,
  output logic        MEM_READ,
  output logic [31:0] PC_OUT,
  output logic        PC_WRITE,
  output logic [31:0] EPC,
  output logic [1:0]  CAUSE,
  output logic        BUSY,
  output logic        EXC_DONE
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_LOAD = 2'd2;
  localparam logic [2:0] CNT_INIT = 3'(MEM_LATENCY - 1);

  logic [1:0]  r_state;
  logic [2:0]  r_cnt;
  logic [7:0]  r_vec;
  logic [31:0] r_epc;
  logic [1:0]  r_cause;

  logic        w_trig;
  logic [1:0]  w_cause;
  logic [7:0]  w_vec;
  logic        w_unused;

  assign w_trig = OPCODE_INVALID | DIV_ZERO | (OVERFLOW & OVF_CHECK);

  // Opcode fault outranks divide-by-zero, which outranks overflow.
  always_comb begin
    w_cause = 2'b11;
    w_vec   = VEC_OVF;
    if (OPCODE_INVALID) begin
      w_cause = 2'b01;
      w_vec   = VEC_OPC;
    end else if (DIV_ZERO) begin
      w_cause = 2'b10;
      w_vec   = VEC_DIV;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 3'd0;
      r_vec   <= 8'd0;
      r_epc   <= 32'd0;
      r_cause <= 2'b00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_trig) begin
            r_state <= S_READ;
            r_cnt   <= CNT_INIT;
            r_vec   <= w_vec;
            r_epc   <= PC - 32'd4;
            r_cause <= w_cause;
          end
        end
        S_READ: begin
          if (r_cnt == 3'd0) begin
            r_state <= S_LOAD;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        S_LOAD: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Only the low byte of the vector word is a handler address.
  assign w_unused = ^MEM_DATA[31:8];

  assign BUSY     = (r_state == S_READ) || (r_state == S_LOAD);
  assign MEM_READ = (r_state == S_READ);
  assign PC_WRITE = (r_state == S_LOAD);
  assign EXC_DONE = (r_state == S_LOAD);
  assign MEM_ADDR = BUSY ? {24'd0, r_vec} : 32'd0;
  assign PC_OUT   = (r_state == S_LOAD) ? {24'd0, MEM_DATA[7:0]} : 32'd0;
  assign EPC      = r_epc;
  assign CAUSE    = r_cause;

endmodule

// File: tb/tb_exception_ctrl.sv
// tb/tb_exception_ctrl.sv - self-checking bench for exception_ctrl
// Schedule-based model plus directed vectors with literal expectations.
module tb_exception_ctrl;

  localparam int L = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        OVERFLOW = 1'b0;
  logic        OVF_CHECK = 1'b0;
  logic        OPCODE_INVALID = 1'b0;
  logic        DIV_ZERO = 1'b0;
  logic [31:0] PC = 32'd0;
  logic [31:0] MEM_DATA;
  logic [31:0] MEM_ADDR;
  logic        MEM_READ;
  logic [31:0] PC_OUT;
  logic        PC_WRITE;
  logic [31:0] EPC;
  logic [1:0]  CAUSE;
  logic        BUSY;
  logic        EXC_DONE;

  logic [31:0] mem [0:255];
  assign MEM_DATA = mem[MEM_ADDR[7:0]];

  exception_ctrl #(.VEC_OPC(8'd254), .VEC_DIV(8'd255), .VEC_OVF(8'd253), .MEM_LATENCY(L)) dut (
    .clk(clk), .reset(reset), .OVERFLOW(OVERFLOW), .OVF_CHECK(OVF_CHECK),
    .OPCODE_INVALID(OPCODE_INVALID), .DIV_ZERO(DIV_ZERO), .PC(PC), .MEM_DATA(MEM_DATA),
    .MEM_ADDR(MEM_ADDR), .MEM_READ(MEM_READ), .PC_OUT(PC_OUT), .PC_WRITE(PC_WRITE),
    .EPC(EPC), .CAUSE(CAUSE), .BUSY(BUSY), .EXC_DONE(EXC_DONE)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: an accepted exception at edge number A occupies READ for cycles A..A+L-1
  // (counting the cycle after edge k as cycle k) and LOAD for cycle A+L.
  int          n = 0;
  int          m_acc = 0;
  bit          m_active = 1'b0;
  logic [31:0] m_epc = 32'd0;
  logic [1:0]  m_cause = 2'd0;
  logic [7:0]  m_vec = 8'd0;

  always @(posedge clk) begin
    if (reset) begin
      m_active <= 1'b0;
      m_epc    <= 32'd0;
      m_cause  <= 2'd0;
    end else if (!(m_active && (n - m_acc) <= L) &&
                 (OPCODE_INVALID || DIV_ZERO || (OVERFLOW && OVF_CHECK))) begin
      m_active <= 1'b1;
      m_acc    <= n + 1;
      m_epc    <= PC - 32'd4;
      m_cause  <= OPCODE_INVALID ? 2'd1 : (DIV_ZERO ? 2'd2 : 2'd3);
      m_vec    <= OPCODE_INVALID ? 8'd254 : (DIV_ZERO ? 8'd255 : 8'd253);
    end
    n <= n + 1;
  end

  always @(negedge clk) begin : cmp
    int p;
    bit rd;
    bit ld;
    if (chk_en) begin
      p  = n - m_acc;
      rd = m_active && (p >= 0) && (p < L);
      ld = m_active && (p == L);
      chk("BUSY", {31'd0, BUSY}, {31'd0, rd || ld});
      chk("MEM_READ", {31'd0, MEM_READ}, {31'd0, rd});
      chk("PC_WRITE", {31'd0, PC_WRITE}, {31'd0, ld});
      chk("EXC_DONE", {31'd0, EXC_DONE}, {31'd0, ld});
      chk("MEM_ADDR", MEM_ADDR, (rd || ld) ? {24'd0, m_vec} : 32'd0);
      chk("PC_OUT", PC_OUT, ld ? {24'd0, mem[m_vec][7:0]} : 32'd0);
      chk("EPC", EPC, m_epc);
      chk("CAUSE", {30'd0, CAUSE}, {30'd0, m_cause});
    end
  end

  task automatic fire(input logic ov, input logic oc, input logic opc, input logic dz,
                      input logic [31:0] pc);
    @(negedge clk);
    #1;
    OVERFLOW = ov; OVF_CHECK = oc; OPCODE_INVALID = opc; DIV_ZERO = dz; PC = pc;
    @(posedge clk);
    #1;
    OVERFLOW = 1'b0; OVF_CHECK = 1'b0; OPCODE_INVALID = 1'b0; DIV_ZERO = 1'b0;
  endtask

  // Cycle i = 1 is the cycle right after the sampling edge.
  task automatic observe(input int ncyc, output int busy_n, output int rd_n,
                         output int pw1, output int pw2, output logic [31:0] pcout1,
                         output logic [31:0] addr1, output logic [1:0] cause1,
                         output logic [31:0] epc1, output logic [1:0] cause2);
    busy_n = 0; rd_n = 0; pw1 = -1; pw2 = -1;
    pcout1 = 32'd0; addr1 = 32'd0; cause1 = 2'd0; epc1 = 32'd0; cause2 = 2'd0;
    for (int i = 1; i <= ncyc; i++) begin
      @(negedge clk);
      if (BUSY) busy_n++;
      if (MEM_READ) begin
        rd_n++;
        if (pw1 < 0) addr1 = MEM_ADDR;
      end
      if (PC_WRITE) begin
        if (pw1 < 0) begin
          pw1 = i; pcout1 = PC_OUT; cause1 = CAUSE; epc1 = EPC;
        end else if (pw2 < 0) begin
          pw2 = i; cause2 = CAUSE;
        end
      end
    end
  endtask

  int          busy_n, rd_n, pw1, pw2;
  logic [31:0] pcout1, addr1, epc1;
  logic [1:0]  cause1, cause2;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    mem[253] = 32'h0000_007C;
    mem[254] = 32'h1122_3344;
    mem[255] = 32'hDEAD_BE12;

    repeat (2) @(posedge clk);
    #1 chk_en = 1'b1;
    @(negedge clk);
    chk("rst_busy", {31'd0, BUSY}, 32'd0);
    chk("rst_pc_write", {31'd0, PC_WRITE}, 32'd0);
    chk("rst_epc", EPC, 32'd0);
    chk("rst_mem_addr", MEM_ADDR, 32'd0);
    #1 reset = 1'b0;

    fire(1'b1, 1'b0, 1'b0, 1'b0, 32'h104);
    observe(5, busy_n, rd_n, pw1, pw2, pcout1, addr1, cause1, epc1, cause2);
    chk("qual_busy_cycles", busy_n, 0);
    chk("qual_no_pc_write", pw1, -1);
    chk("qual_cause", {30'd0, CAUSE}, 32'd0);

    fire(1'b1, 1'b1, 1'b0, 1'b0, 32'h104);
    observe(5, busy_n, rd_n, pw1, pw2, pcout1, addr1, cause1, epc1, cause2);
    chk("ovf_epc", epc1, 32'h100);
    chk("ovf_cause", {30'd0, cause1}, 32'd3);
    chk("ovf_mem_addr", addr1, 32'd253);
    chk("ovf_read_cycles", rd_n, 2);
    chk("ovf_pc_write_cycle", pw1, 3);
    chk("ovf_pc_out", pcout1, 32'h7C);
    chk("ovf_busy_cycles", busy_n, 3);

    fire(1'b1, 1'b1, 1'b1, 1'b1, 32'h204);
    observe(5, busy_n, rd_n, pw1, pw2, pcout1, addr1, cause1, epc1, cause2);
    chk("prio_cause", {30'd0, cause1}, 32'd1);
    chk("prio_mem_addr", addr1, 32'd254);
    chk("prio_pc_out", pcout1, 32'h44);
    chk("prio_epc", epc1, 32'h200);

    @(negedge clk);
    #1;
    PC = 32'h20; DIV_ZERO = 1'b1;
    @(posedge clk);
    #1;
    DIV_ZERO = 1'b0; OPCODE_INVALID = 1'b1;
    observe(7, busy_n, rd_n, pw1, pw2, pcout1, addr1, cause1, epc1, cause2);
    #1 OPCODE_INVALID = 1'b0;
    chk("b2b_first_cause", {30'd0, cause1}, 32'd2);
    chk("b2b_first_epc", epc1, 32'h1C);
    chk("b2b_first_pc_write", pw1, 3);
    chk("b2b_second_pc_write", pw2, 7);
    chk("b2b_second_cause", {30'd0, cause2}, 32'd1);
    chk("b2b_busy_cycles", busy_n, 6);
    observe(4, busy_n, rd_n, pw1, pw2, pcout1, addr1, cause1, epc1, cause2);
    chk("b2b_drained", busy_n, 0);

    @(negedge clk);
    #1;
    PC = 32'h300; DIV_ZERO = 1'b1;
    @(posedge clk);
    #1;
    DIV_ZERO = 1'b0; reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("midrst_busy", {31'd0, BUSY}, 32'd0);
    chk("midrst_mem_read", {31'd0, MEM_READ}, 32'd0);
    chk("midrst_mem_addr", MEM_ADDR, 32'd0);
    chk("midrst_pc_write", {31'd0, PC_WRITE}, 32'd0);
    chk("midrst_exc_done", {31'd0, EXC_DONE}, 32'd0);
    chk("midrst_pc_out", PC_OUT, 32'd0);
    chk("midrst_epc", EPC, 32'd0);
    chk("midrst_cause", {30'd0, CAUSE}, 32'd0);
    observe(6, busy_n, rd_n, pw1, pw2, pcout1, addr1, cause1, epc1, cause2);
    chk("midrst_no_pc_write", pw1, -1);
    chk("midrst_busy_cycles", busy_n, 0);

    fire(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    observe(5, busy_n, rd_n, pw1, pw2, pcout1, addr1, cause1, epc1, cause2);
    chk("wrap_epc", epc1, 32'hFFFF_FFFC);
    chk("wrap_pc_out", pcout1, 32'h12);
    chk("wrap_cause", {30'd0, cause1}, 32'd2);
    chk("wrap_pc_write_cycle", pw1, 3);

    @(negedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
